// File: rtl/simd_loop_replay_ctrl.sv
// simd_loop_replay_ctrl
//   Loop-body capture/replay stage placed in front of the iterator address
//   generator. Iteration 0 of a single-level loop is issued live while being
//   written into a local body buffer; iterations 1..iters-1 are replayed from
//   that buffer with in_single_loop set so the iterator does base+stride
//   write-back. With no loop active the block is a registered one-entry
//   pass-through.
// Ports
//   clk, reset                          clock, synchronous active-high reset
//   loop_cfg_valid/ready/iters/num_inst loop configuration handshake
//   inst_in_valid/ready, inst_in        upstream instruction stream
//   inst_out_valid/ready, inst_out      downstream instruction stream (registered)
//   in_single_loop                      inst_out is a replayed beat (iteration >= 1)
//   loop_busy, loop_done, iter_count    loop status
module simd_loop_replay_ctrl #(
  parameter int INST_WIDTH     = 32,
  parameter int BODY_ADDR_BITS = 5,
  parameter int MAX_BODY       = 32,
  parameter int ITER_WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    loop_cfg_valid,
  output logic                    loop_cfg_ready,
  input  logic [ITER_WIDTH-1:0]   loop_cfg_iters,
  input  logic [BODY_ADDR_BITS:0] loop_cfg_num_inst,
  input  logic                    inst_in_valid,
  output logic                    inst_in_ready,
  input  logic [INST_WIDTH-1:0]   inst_in,
  output logic                    inst_out_valid,
  input  logic                    inst_out_ready,
  output logic [INST_WIDTH-1:0]   inst_out,
  output logic                    in_single_loop,
  output logic                    loop_busy,
  output logic                    loop_done,
  output logic [ITER_WIDTH-1:0]   iter_count
);
  localparam int NW = BODY_ADDR_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_REPLAY} state_t;
  state_t r_state, w_state_nxt;

  logic [INST_WIDTH-1:0]     r_body [MAX_BODY];
  logic [BODY_ADDR_BITS-1:0] r_wr_ptr, r_rd_ptr, r_last;
  logic [ITER_WIDTH-1:0]     r_iters, r_iter_count;
  logic                      r_out_valid, r_single, r_done;
  logic [INST_WIDTH-1:0]     r_out;

  logic                      w_free, w_in_ready, w_cfg_ok, w_done_nxt;
  logic                      w_idle_fire, w_cap_fire, w_rep_fire, w_load;
  logic                      w_cap_last, w_rep_wrap;
  logic [NW-1:0]             w_num_sat;
  logic [BODY_ADDR_BITS-1:0] w_last;
  logic [INST_WIDTH-1:0]     w_src;

  // Bodies longer than the buffer are clamped; keep the last index, not the count.
  assign w_num_sat  = (loop_cfg_num_inst > NW'(MAX_BODY)) ? NW'(MAX_BODY) : loop_cfg_num_inst;
  assign w_last     = BODY_ADDR_BITS'(w_num_sat - NW'(1));
  assign w_free     = ~r_out_valid | inst_out_ready;
  assign w_cap_last = (r_wr_ptr == r_last);
  assign w_rep_wrap = (r_rd_ptr == r_last);
  assign w_load     = w_idle_fire | w_cap_fire | w_rep_fire;
  // Asynchronous body read keeps replay bubble-free across iteration wraps.
  assign w_src      = w_rep_fire ? r_body[r_rd_ptr] : inst_in;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_cfg_ok    = 1'b0;
    w_done_nxt  = 1'b0;
    w_idle_fire = 1'b0;
    w_cap_fire  = 1'b0;
    w_rep_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A config strobe blocks the same-cycle instruction.
        w_in_ready  = w_free & ~loop_cfg_valid;
        w_idle_fire = w_in_ready & inst_in_valid;
        if (loop_cfg_valid) begin
          if (loop_cfg_iters == '0 || loop_cfg_num_inst == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_cfg_ok    = 1'b1;
            w_state_nxt = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        w_in_ready = w_free;
        w_cap_fire = w_free & inst_in_valid;
        if (w_cap_fire && w_cap_last) begin
          if (r_iters == ITER_WIDTH'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_REPLAY;
          end
        end
      end
      S_REPLAY: begin
        w_rep_fire = w_free;
        if (w_free && w_rep_wrap && r_iter_count == r_iters - ITER_WIDTH'(1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_single     <= 1'b0;
      r_done       <= 1'b0;
      r_iter_count <= '0;
      r_iters      <= '0;
      r_last       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_done <= w_done_nxt;
      if (w_free) begin
        r_out_valid <= w_load;
        r_single    <= w_rep_fire;
        if (w_load) r_out <= w_src;
      end
      if (w_cfg_ok) begin
        r_iters      <= loop_cfg_iters;
        r_last       <= w_last;
        r_wr_ptr     <= '0;
        r_iter_count <= '0;
      end
      if (w_cap_fire) begin
        r_wr_ptr <= r_wr_ptr + BODY_ADDR_BITS'(1);
        if (w_cap_last) begin
          // iter_count counts completed iterations; 1 once iteration 0 is out.
          r_iter_count <= ITER_WIDTH'(1);
          r_rd_ptr     <= '0;
        end
      end
      if (w_rep_fire) begin
        if (w_rep_wrap) begin
          r_rd_ptr     <= '0;
          r_iter_count <= r_iter_count + ITER_WIDTH'(1);
        end else begin
          r_rd_ptr <= r_rd_ptr + BODY_ADDR_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap_fire) r_body[r_wr_ptr] <= inst_in;
  end

  // Handshake readies are forced low while reset is held.
  assign loop_cfg_ready = (r_state == S_IDLE) & ~reset;
  assign inst_in_ready  = w_in_ready & ~reset;
  assign inst_out_valid = r_out_valid;
  assign inst_out       = r_out;
  assign in_single_loop = r_single;
  assign loop_busy      = (r_state != S_IDLE);
  assign loop_done      = r_done;
  assign iter_count     = r_iter_count;
endmodule

// File: tb/tb_simd_loop_replay_ctrl.sv
module tb_simd_loop_replay_ctrl;
  localparam int IW = 32, AB = 5, MB = 32, ITW = 16;
  localparam int BUDGET = 1500;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loop_cfg_valid = 1'b0, loop_cfg_ready;
  logic [ITW-1:0] loop_cfg_iters = '0;
  logic [AB:0] loop_cfg_num_inst = '0;
  logic inst_in_valid = 1'b0, inst_in_ready;
  logic [IW-1:0] inst_in = '0;
  logic inst_out_valid, inst_out_ready = 1'b1;
  logic [IW-1:0] inst_out;
  logic in_single_loop, loop_busy, loop_done;
  logic [ITW-1:0] iter_count;

  simd_loop_replay_ctrl #(.INST_WIDTH(IW), .BODY_ADDR_BITS(AB), .MAX_BODY(MB), .ITER_WIDTH(ITW)) dut (
    .clk(clk), .reset(reset),
    .loop_cfg_valid(loop_cfg_valid), .loop_cfg_ready(loop_cfg_ready),
    .loop_cfg_iters(loop_cfg_iters), .loop_cfg_num_inst(loop_cfg_num_inst),
    .inst_in_valid(inst_in_valid), .inst_in_ready(inst_in_ready), .inst_in(inst_in),
    .inst_out_valid(inst_out_valid), .inst_out_ready(inst_out_ready), .inst_out(inst_out),
    .in_single_loop(in_single_loop), .loop_busy(loop_busy), .loop_done(loop_done),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  // Beat monitor: downstream transfers, done pulses, stall stability, iter_count trace.
  logic [IW:0]    got_q[$];
  int             got_cyc[$];
  logic [ITW-1:0] ic_q[$];
  logic [ITW-1:0] ic_last = '0;
  int done_cnt = 0, done_cyc = -1, stall_err = 0, busy_cnt = 0;
  logic prev_stall = 1'b0;
  logic [IW:0] prev_beat = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (inst_out_valid !== 1'b1 || {in_single_loop, inst_out} !== prev_beat))
        stall_err++;
      if (inst_out_valid && inst_out_ready) begin
        got_q.push_back({in_single_loop, inst_out});
        got_cyc.push_back(cyc);
      end
      prev_stall = inst_out_valid && !inst_out_ready;
      prev_beat  = {in_single_loop, inst_out};
      if (loop_done) begin done_cnt++; done_cyc = cyc; end
      if (loop_busy) busy_cnt++;
      if (iter_count != ic_last) begin ic_q.push_back(iter_count); ic_last = iter_count; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    got_q.delete(); got_cyc.delete(); ic_q.delete();
    ic_last = iter_count; done_cnt = 0; done_cyc = -1; stall_err = 0; busy_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    tests++;
    if ({inst_out_valid, in_single_loop, loop_busy, loop_done, iter_count, inst_out} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b s=%b busy=%b done=%b ic=%0d out=%h, required all 0",
               inst_out_valid, in_single_loop, loop_busy, loop_done, iter_count, inst_out);
    end
    tests++;
    if ({loop_cfg_ready, inst_in_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_readies: got cfg_rdy=%b in_rdy=%b, required 0 0", loop_cfg_ready, inst_in_ready);
    end
    tick(); reset = 1'b0; tick();
    @(negedge clk);
    tests++;
    if (loop_cfg_ready !== 1'b1 || inst_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_ready: got cfg_rdy=%b in_rdy=%b, required 1 1", loop_cfg_ready, inst_in_ready);
    end
    tick();
  endtask

  task automatic test_passthrough();
    logic [IW-1:0] w[5];
    int pres[5];
    int bad = 0;
    clear_mon();
    inst_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      inst_in_valid = 1'b1; inst_in = w[i];
      @(negedge clk);
      pres[i] = cyc;
      if (!inst_in_ready) bad++;
      tick();
    end
    inst_in_valid = 1'b0;
    repeat (3) tick();
    tests++;
    if (got_q.size() != 5 || bad != 0) begin
      fails++;
      $display("FAIL pass_count: got %0d beats (%0d not ready), required 5 beats", got_q.size(), bad);
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (got_q[i] !== {1'b0, w[i]} || got_cyc[i] != pres[i] + 1) begin
          fails++;
          $display("FAIL pass_beat%0d: got %h at cyc %0d, required %h at cyc %0d",
                   i, got_q[i], got_cyc[i], {1'b0, w[i]}, pres[i] + 1);
        end
      end
    end
    tests++;
    if (done_cnt != 0) begin
      fails++;
      $display("FAIL pass_no_done: got %0d loop_done pulses, required 0", done_cnt);
    end
  endtask

  // bp: 0 ready always high, 1 one-on/two-off, 2 random
  task automatic run_loop(input int iters, input int num, input int bp, input string name);
    logic [IW-1:0] body[MB];
    int nsat, exp_n, k, acc, t, w, bad, first, p;
    logic a, ok;
    logic [IW:0] ev;
    nsat = (num > MB) ? MB : num;
    exp_n = iters * nsat;
    for (int i = 0; i < MB; i++) body[i] = $urandom;
    inst_out_ready = 1'b1; inst_in_valid = 1'b0;
    w = 0;
    while (loop_cfg_ready !== 1'b1 && w < 100) begin tick(); w++; end
    clear_mon();
    loop_cfg_valid = 1'b1; loop_cfg_iters = ITW'(iters); loop_cfg_num_inst = (AB+1)'(num);
    tick();
    loop_cfg_valid = 1'b0;
    k = 0; acc = 0; t = 0;
    while ((got_q.size() < exp_n || done_cnt == 0) && t < BUDGET) begin
      inst_out_ready = (bp == 0) ? 1'b1 : (bp == 1) ? (t % 3 == 0) : 1'($urandom);
      // A config strobe while busy must be ignored.
      loop_cfg_valid = (t == 0);
      loop_cfg_iters = 7; loop_cfg_num_inst = 1;
      if (k < nsat) begin inst_in_valid = 1'b1; inst_in = body[k]; end
      else if (loop_busy) begin inst_in_valid = 1'b1; inst_in = $urandom; end
      else inst_in_valid = 1'b0;
      @(negedge clk);
      if (t == 0) begin
        tests++;
        if (loop_cfg_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s cfg_ready_busy: got %b, required 0", name, loop_cfg_ready);
        end
      end
      a = inst_in_valid && inst_in_ready;
      tick();
      if (a) begin acc++; if (k < nsat) k++; end
      t++;
    end
    loop_cfg_valid = 1'b0; inst_in_valid = 1'b0; inst_out_ready = 1'b1;
    repeat (4) tick();
    tests++;
    if (t >= BUDGET) begin
      fails++;
      $display("FAIL %s timeout: got %0d beats done=%0d, required %0d beats and done", name, got_q.size(), done_cnt, exp_n);
    end
    tests++;
    if (got_q.size() != exp_n) begin
      fails++;
      $display("FAIL %s beat_count: got %0d, required %0d", name, got_q.size(), exp_n);
    end
    bad = 0; first = -1;
    for (int b = 0; b < got_q.size() && b < exp_n; b++) begin
      ev = {1'(b >= nsat), body[b % nsat]};
      if (got_q[b] !== ev) begin bad++; if (first < 0) first = b; end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s sequence: %0d bad beats, first #%0d got %h required %h", name, bad, first,
               got_q[first], {1'(first >= nsat), body[first % nsat]});
    end
    tests++;
    if (acc != nsat) begin
      fails++;
      $display("FAIL %s accepted: got %0d upstream accepts, required %0d", name, acc, nsat);
    end
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL %s done_count: got %0d, required 1", name, done_cnt);
    end
    tests++;
    if (stall_err != 0) begin
      fails++;
      $display("FAIL %s stall_stable: got %0d changes while stalled, required 0", name, stall_err);
    end
    tests++;
    if (iter_count !== ITW'(iters) || loop_cfg_ready !== 1'b1 || loop_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s end_state: got ic=%0d cfg_rdy=%b busy=%b, required ic=%0d 1 0",
               name, iter_count, loop_cfg_ready, loop_busy, iters);
    end
    p = (ic_q.size() > 0 && ic_q[0] == 0) ? 1 : 0;
    ok = (ic_q.size() - p == iters);
    for (int j = 0; ok && j < iters; j++) if (ic_q[p + j] != ITW'(j + 1)) ok = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s iter_trace: got %0d steps, required 1..%0d", name, ic_q.size() - p, iters);
    end
    if (bp == 0 && got_q.size() == exp_n) begin
      tests++;
      if (got_cyc[exp_n-1] - got_cyc[0] != exp_n - 1 || done_cyc != got_cyc[exp_n-1]) begin
        fails++;
        $display("FAIL %s timing: got span %0d done@%0d, required span %0d done@%0d", name,
                 got_cyc[exp_n-1] - got_cyc[0], done_cyc, exp_n - 1, got_cyc[exp_n-1]);
      end
    end
  endtask

  task automatic test_degenerate();
    int c;
    for (int i = 0; i < 2; i++) begin
      clear_mon();
      inst_out_ready = 1'b1;
      loop_cfg_valid = 1'b1;
      loop_cfg_iters = (i == 0) ? 0 : 5;
      loop_cfg_num_inst = (i == 0) ? 3 : 0;
      inst_in_valid = 1'b1; inst_in = $urandom;
      @(negedge clk);
      c = cyc;
      tests++;
      if (inst_in_ready !== 1'b0 || loop_cfg_ready !== 1'b1) begin
        fails++;
        $display("FAIL degen%0d cfg_priority: got in_rdy=%b cfg_rdy=%b, required 0 1", i, inst_in_ready, loop_cfg_ready);
      end
      tick();
      loop_cfg_valid = 1'b0; inst_in_valid = 1'b0;
      repeat (3) tick();
      tests++;
      if (done_cnt != 1 || done_cyc != c + 1 || got_q.size() != 0 || busy_cnt != 0) begin
        fails++;
        $display("FAIL degen%0d: got done=%0d@%0d beats=%0d busy=%0d, required 1@%0d 0 0",
                 i, done_cnt, done_cyc, got_q.size(), busy_cnt, c + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [IW-1:0] w;
    int t;
    inst_out_ready = 1'b1;
    loop_cfg_valid = 1'b1; loop_cfg_iters = 4; loop_cfg_num_inst = 3;
    tick();
    loop_cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin inst_in_valid = 1'b1; inst_in = $urandom; tick(); end
    inst_in_valid = 1'b0;
    t = 0;
    while (iter_count !== 2 && t < 50) begin tick(); t++; end
    tests++;
    if (t >= 50 || loop_busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_reach: got ic=%0d busy=%b, required ic=2 busy=1", iter_count, loop_busy);
    end
    clear_mon();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    tests++;
    if (inst_out_valid !== 1'b0 || loop_busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_abort: got v=%b busy=%b, required 0 0", inst_out_valid, loop_busy);
    end
    repeat (5) tick();
    tests++;
    if (done_cnt != 0) begin
      fails++;
      $display("FAIL rstmid_no_done: got %0d pulses, required 0", done_cnt);
    end
    clear_mon();
    w = $urandom;
    inst_in_valid = 1'b1; inst_in = w;
    tick();
    inst_in_valid = 1'b0;
    repeat (2) tick();
    tests++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, w}) begin
      fails++;
      $display("FAIL rstmid_pass: got %0d beats first=%h, required 1 beat %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0, {1'b0, w});
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    run_loop(4, 3, 0, "loop3x4");
    test_degenerate();
    run_loop(1, 2, 0, "iters1");
    run_loop(4, 3, 1, "backpressure");
    run_loop(2, 32, 0, "full32");
    run_loop(2, 40, 0, "sat40");
    for (int r = 0; r < 4; r++)
      run_loop($urandom_range(1, 5), $urandom_range(1, 40), 2, "random");
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
